image_raster_fetcher: RTL

- Initiator for the pixel-ROM image container. It walks a stored frame in raster order, issues one read request per pixel (index + enable), and waits for the container's pixel-valid strobe.
- Each returned pixel is forwarded downstream with row/column tags and a valid/ready handshake.
- It sits between the test image store and the face detection datapath input.

---
 rtl/image_raster_fetcher.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/image_raster_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : image_raster_fetcher
// Description : Walks a stored frame in raster order, issuing one pixel read
//               at a time and forwarding each returned pixel downstream with
//               row/column tags over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module image_raster_fetcher #(
    parameter int DATA_WIDTH_8  = 8,
    parameter int DATA_WIDTH_16 = 16,
    parameter int IMAGE_WIDTH   = 4,
    parameter int IMAGE_HEIGHT  = 3,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     o_enable,
    output logic [DATA_WIDTH_16-1:0] o_coordinate_index,
    input  logic [DATA_WIDTH_8-1:0]  i_pixel,
    input  logic                     i_pixel_valid,
    output logic [DATA_WIDTH_8-1:0]  o_pixel,
    output logic [DATA_WIDTH_16-1:0] o_row,
    output logic [DATA_WIDTH_16-1:0] o_col,
    output logic                     o_pixel_valid,
    input  logic                     i_ready,
    output logic                     o_end_of_row,
    output logic                     o_end_of_frame,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_OUT  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    // The wait counter only needs to reach TIMEOUT-1 before giving up.
    localparam int                     c_TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_TMO_W-1:0]     c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH_16-1:0] c_LAST_COL = DATA_WIDTH_16'(IMAGE_WIDTH - 1);
    localparam logic [DATA_WIDTH_16-1:0] c_LAST_ROW = DATA_WIDTH_16'(IMAGE_HEIGHT - 1);

    logic [2:0]               r_state;
    logic [DATA_WIDTH_16-1:0] r_index;
    logic [DATA_WIDTH_16-1:0] r_row;
    logic [DATA_WIDTH_16-1:0] r_col;
    logic [c_TMO_W-1:0]       r_tmo;
    logic                     r_enable;
    logic [DATA_WIDTH_8-1:0]  r_pixel;
    logic [DATA_WIDTH_16-1:0] r_out_row;
    logic [DATA_WIDTH_16-1:0] r_out_col;
    logic                     r_valid;
    logic                     r_eor;
    logic                     r_eof;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_error;

    logic w_last_col;
    logic w_last_row;

    assign w_last_col = (r_col == c_LAST_COL);
    assign w_last_row = (r_row == c_LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_index   <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_tmo     <= '0;
            r_enable  <= 1'b0;
            r_pixel   <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_valid   <= 1'b0;
            r_eor     <= 1'b0;
            r_eof     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_error  <= 1'b0;
                        r_index  <= '0;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= c_ST_REQ;
                    end
                end
                c_ST_REQ: begin
                    r_tmo   <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // A strobe on the final allowed cycle still wins over the timeout.
                    if (i_pixel_valid) begin
                        r_pixel   <= i_pixel;
                        r_out_row <= r_row;
                        r_out_col <= r_col;
                        r_eor     <= w_last_col;
                        r_eof     <= w_last_col & w_last_row;
                        r_valid   <= 1'b1;
                        r_state   <= c_ST_OUT;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_OUT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_eor   <= 1'b0;
                        r_eof   <= 1'b0;
                        if (r_eof) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_col <= r_col + 1'b1;
                            end
                            r_enable <= 1'b1;
                            r_state  <= c_ST_REQ;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_enable           = r_enable;
    assign o_coordinate_index = r_index;
    assign o_pixel            = r_pixel;
    assign o_row              = r_out_row;
    assign o_col              = r_out_col;
    assign o_pixel_valid      = r_valid;
    assign o_end_of_row       = r_eor;
    assign o_end_of_frame     = r_eof;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_error            = r_error;

endmodule
`default_nettype wire
